// File: rtl/fifo_packer.sv
// fifo_packer: packs FWFT FIFO lanes into ratio-lane little-endian words with flush and backpressure
module fifo_packer #(
  parameter int data_width = 8,
  parameter int ratio = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [data_width-1:0]         fifo_data,
  input  logic                          fifo_empty,
  output logic                          fifo_read_en,
  input  logic                          flush,
  output logic [data_width*ratio-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic [$clog2(ratio):0]        out_count
);
  localparam int cw = $clog2(ratio) + 1;
  localparam int iw = $clog2(ratio);
  logic [ratio-1:0][data_width-1:0] acc_q, acc_d, word_q, word_d;
  logic [cw-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic fp_q, fp_d, vld_q, vld_d, move, pop;
  logic [iw-1:0] idx;
  always_comb begin
    move = (!vld_q || out_ack) && (cnt_q == cw'(ratio) || (fp_q && cnt_q != '0));
    pop = !fifo_empty && !sys_rst && !fp_q && (cnt_q < cw'(ratio) || move);
    idx = move ? '0 : cnt_q[iw-1:0];
    acc_d = acc_q;
    cnt_d = move ? '0 : cnt_q;
    word_d = word_q;
    ocnt_d = ocnt_q;
    vld_d = move || (vld_q && !out_ack);
    fp_d = !move && !(fp_q && cnt_q == '0) && (fp_q || flush);
    if (move) begin
      ocnt_d = cnt_q;
      for (int k = 0; k < ratio; k++) word_d[k] = cw'(k) < cnt_q ? acc_q[k] : '0;
    end
    if (pop) begin
      acc_d[idx] = fifo_data;
      cnt_d = cnt_d + cw'(1);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      ocnt_q <= '0;
      vld_q <= 1'b0;
      fp_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      ocnt_q <= ocnt_d;
      vld_q <= vld_d;
      fp_q <= fp_d;
    end
  end
  assign fifo_read_en = pop;
  assign out_data = word_q;
  assign out_valid = vld_q;
  assign out_count = ocnt_q;
endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter data_width, default 8, lane width in bits.
REQ-002 Parameter ratio, default 4, lanes per output word; power of two, at least 2.
REQ-003 Port sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port sys_rst  input  1  synchronous, active-high reset.
REQ-005 Port fifo_data  input  data_width  first-word-fall-through read data from the upstream asynchronous FIFO; valid while fifo_empty=0.
REQ-006 Port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 Port fifo_read_en  output  1  pops one lane from the upstream FIFO at the rising edge.
REQ-008 Port flush  input  1  single-cycle request to emit the partially assembled word.
REQ-009 Port out_data  output  data_width*ratio  assembled word; lane k occupies bits [k*data_width +: data_width], little-endian.
REQ-010 Port out_valid  output  1  out_data/out_count hold a word.
REQ-011 Port out_ack  input  1  consumer accepts; a transfer occurs on an edge where out_valid=1 and out_ack=1.
REQ-012 Port out_count  output  log2(ratio)+1  number of valid lanes in out_data, 1..ratio.

Function
REQ-013 The block SHALL hold an accumulator of ratio lanes with acc_count 0..ratio, plus one output register.
REQ-014 "out_free" SHALL be (out_valid=0) or (out_ack=1).
REQ-015 "move" SHALL be true when out_free and either acc_count=ratio, or (flush_pending=1 and acc_count>0).
REQ-016 fifo_read_en SHALL be combinational: fifo_empty=0 and sys_rst=0 and flush_pending=0 and (acc_count<ratio or move).
REQ-017 Each popped lane SHALL be written to lane acc_count, and acc_count SHALL be incremented; the first lane popped goes to lane 0.
REQ-018 On move, the accumulator SHALL be copied to out_data with unused lanes forced to zero, out_count SHALL equal acc_count, and out_valid SHALL be 1.
REQ-019 On the same edge as a move, a simultaneous pop SHALL land in lane 0 and leave acc_count=1; otherwise acc_count SHALL be 0. This sustains one lane per cycle with no bubble.
REQ-020 On a transfer without a move, out_valid SHALL fall to 0; out_data SHALL hold its value while out_valid=1 and out_ack=0.
REQ-021 flush=1 SHALL set flush_pending; flush_pending SHALL block pops and clear on the edge of the move.
REQ-022 If flush arrives with acc_count=0, flush_pending SHALL clear on the next edge and no word SHALL be emitted.
REQ-023 If flush arrives with acc_count=ratio, a normal full word (out_count=ratio) SHALL be emitted and flush_pending SHALL clear.
REQ-024 A flush that arrives while flush_pending=1 SHALL be absorbed without emitting an extra word.
REQ-025 Latency: the lane completing a word SHALL appear at out_data on the edge after its pop if out_free; otherwise it SHALL appear on the first edge with out_free=1.
REQ-026 out_ack while out_valid=0 SHALL be ignored; no lane SHALL ever be dropped or duplicated.

Reset
REQ-027 While sys_rst=1: fifo_read_en=0, and after the edge out_valid=0, out_data=0, out_count=0, acc_count=0, flush_pending=0.
REQ-028 Reset mid-word SHALL discard the accumulated lanes and the held output word; already-popped lanes are lost by design.

Structure
REQ-029 No shared package is needed; the count width SHALL be derived locally from ratio as a localparam.
REQ-030 The block SHALL be a single module with no sub-module; the lane write decode is inline.

Verification
REQ-031 Streaming: ratio=4, bytes 01..08 always available, out_ack=1 -> words 0x04030201 then 0x08070605 with out_count=4, fifo_read_en high for 8 consecutive cycles.
REQ-032 Backpressure: out_ack=0 after the first word -> fifo_read_en drops after 4 further pops and out_data holds 0x04030201; out_ack=1 -> 0x08070605 follows with no loss.
REQ-033 Partial flush: pop AA, BB, then pulse flush -> single word 0x0000BBAA with out_count=2; pops blocked until the move.
REQ-034 Empty flush: flush with acc_count=0 -> no out_valid, flush_pending clear after 1 cycle.
REQ-035 Upstream gaps: fifo_empty toggles every cycle -> fifo_read_en never high when fifo_empty=1; word order intact.
REQ-036 Reset mid-word: after 3 pops assert sys_rst -> out_valid=0; the next 4 pops form a fresh word starting at lane 0.
